instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: the inverse of the immediate generator.
- Accepts decoded fields (format, opcode, funct3/funct7, registers, 32-bit immediate) and emits packed 32-bit instruction words.
- Range-checks immediates and expands the LI pseudo-instruction into LUI+ADDI when needed.
- Sits between the self-test/boot sequencer and instruction-memory write port; valid/ready on both sides.

Parameters:
- CHECK_EN, 1, 1 = drive out_err on range violations; 0 = out_err tied 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHIFT, 7=LI
- in_opcode  in  7  base opcode; ignored for LI
- in_funct3  in  3  funct3; ignored for U/J/LI
- in_funct7  in  7  funct7; used for R and SHIFT only
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate as a signed byte-offset value; for U, the full shifted value
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range for this word (word still emitted, truncated)
- out_last  out  1  final word of the current request

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=EMPTY, out_valid=0, out_instr=0, out_err=0, out_last=0, in_ready=1 from the cycle after rst is sampled high. Reset mid-request discards the held or pending word.
- Transfers: a transfer occurs on valid&&ready. Latency is 1 cycle: a request accepted at edge N is visible on out_* after edge N.
- FSM states:
  - EMPTY: in_ready=1.
  - HOLD: one word held. in_ready = out_ready, so back-to-back throughput is 1 word/cycle.
  - LI_HI: LUI held, ADDI pending. in_ready=0.
- Transitions:
  - EMPTY + accept → HOLD, or LI_HI for a two-word LI.
  - HOLD + out_ready + accept → HOLD or LI_HI, loading the new word.
  - HOLD + out_ready, no accept → EMPTY.
  - LI_HI + out_ready → HOLD with the ADDI word and out_last=1.
  - Any state with out_ready=0 → hold; out_* stable.
- Packing:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - SHIFT: {f7,imm[4:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Range checks (error → out_err=1 on that word; encoding uses truncated bits):
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094], imm[0]=0.
  - J: imm in [-2^20, 2^20-2], imm[0]=0.
  - U: imm[11:0]=0.
  - SHIFT: imm[31:5]=0.
  - R: never errors.
- LI rd, imm (never errors):
  - imm in [-2048, 2047] → single ADDI rd,x0,imm.
  - Else if imm[11:0]=0 → single LUI rd,imm[31:12].
  - Else two words: LUI rd,hi then ADDI rd,rd,lo, where lo=imm[11:0] (signed) and hi=(imm+0x800)[31:12] (32-bit wrap).
  - The first word has out_last=0.
- out_last=1 on every single-word request.
- in_* are sampled only on accept; the encoder never reads them while holding a word.

Decomposition:
- Shared package:
  - fmt encodings FMT_R..FMT_LI.
  - Opcode constants OP_LUI=0110111, OP_OPIMM=0010011, OP_BRANCH=1100011, OP_JAL=1101111.
  - Immediate range limits.
- Sub-module instr_pack: purely combinational field packer plus range check (fmt, fields, imm → instr, err). It is the exact dual of immGen, and the verifier closes the loop through immGen. The FSM and output register live in instr_encoder.

Test Plan:
- I, op=0x13, f3=0, rd=1, rs1=0, imm=-1 → out_instr=0xFFF00093, out_err=0, out_last=1, one cycle after accept.
- LI rd=5, imm=0x12345FFF with out_ready=1 → 0x123462B7 (last=0), then 0xFFF28293 (last=1); in_ready=0 during LI_HI.
- B, op=0x63, f3=0, rs1=1, rs2=2, imm=-8 → 0xFE208CE3. Same request with imm=3 → out_err=1.
- J, op=0x6F, rd=1, imm=2048 → 0x001000EF. Same request with imm=0x100000 → out_err=1.
- Backpressure: out_ready=0 for 5 cycles after accept → out_instr stable, in_ready=0, no extra accepts; release → word consumed and the next request accepted the same cycle.
- Assert rst while in LI_HI → the next cycle has out_valid=0, in_ready=1, and the pending ADDI is never emitted.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared format/opcode encodings and immediate limits for the RV32I encoder
package instr_encoder_pkg;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHIFT, FMT_LI} fmt_e;
    typedef enum logic [1:0] {EMPTY, HOLD, LI_HI} state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

    function automatic logic in_range(input logic signed [31:0] v, input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return v >= lo && v <= hi;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational RV32I field packer with immediate range check
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);
    fmt_e f;
    assign f = fmt_e'(fmt);
    assign instr =
        f == FMT_R     ? {funct7, rs2, rs1, funct3, rd, opcode} :
        f == FMT_I     ? {imm[11:0], rs1, funct3, rd, opcode} :
        f == FMT_SHIFT ? {funct7, imm[4:0], rs1, funct3, rd, opcode} :
        f == FMT_S     ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
        f == FMT_B     ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
        f == FMT_U     ? {imm[31:12], rd, opcode} :
        f == FMT_J     ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
        32'd0;
    assign err =
        (f == FMT_I || f == FMT_S) ? !in_range(imm, IMM12_MIN, IMM12_MAX) :
        f == FMT_B     ? !in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0] :
        f == FMT_J     ? !in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0] :
        f == FMT_U     ? imm[11:0] != 12'd0 :
        f == FMT_SHIFT ? imm[31:5] != 27'd0 :
        1'b0;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with one-word output register and LI expansion
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);
    state_e      state;
    logic [31:0] pend, li_hi, pk_instr;
    logic [2:0]  pk_fmt;
    logic        pk_err, is_li, li_short, li_two, accept;

    assign is_li    = in_fmt == FMT_LI;
    assign li_short = in_range(in_imm, IMM12_MIN, IMM12_MAX);
    assign li_two   = is_li && !li_short && in_imm[11:0] != 12'd0;
    // Rounding by 0x800 pre-compensates the sign extension of the trailing ADDI
    assign li_hi    = (in_imm + 32'h800) & 32'hFFFF_F000;
    assign pk_fmt   = !is_li ? in_fmt : li_short ? FMT_I : FMT_U;

    instr_pack u_pack (
        .fmt(pk_fmt),
        .opcode(!is_li ? in_opcode : li_short ? OP_OPIMM : OP_LUI),
        .funct3(is_li ? 3'd0 : in_funct3),
        .funct7(in_funct7),
        .rd(in_rd),
        .rs1(is_li ? 5'd0 : in_rs1),
        .rs2(in_rs2),
        .imm(is_li && !li_short ? li_hi : in_imm),
        .instr(pk_instr),
        .err(pk_err)
    );

    assign in_ready  = state == EMPTY || (state == HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = state != EMPTY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            pend      <= 32'd0;
        end else if (accept) begin
            state     <= li_two ? LI_HI : HOLD;
            out_instr <= pk_instr;
            out_err   <= CHECK_EN && !is_li && pk_err;
            out_last  <= !li_two;
            pend      <= {in_imm[11:0], in_rd, 3'd0, in_rd, OP_OPIMM};
        end else if (out_ready && state == LI_HI) begin
            state     <= HOLD;
            out_instr <= pend;
            out_err   <= 1'b0;
            out_last  <= 1'b1;
        end else if (out_ready) begin
            state     <= EMPTY;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed test-plan steps plus randomized traffic checked via an immGen-style decode model
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_err, out_last;
    logic [2:0] in_fmt, in_funct3;
    logic [6:0] in_opcode, in_funct7;
    logic [4:0] in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;

    int n_cmp = 0, n_err = 0;

    typedef struct {logic [2:0] f; logic [65:0] v;} exp_t;
    exp_t exp_q[$];

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int imm);
        in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    endtask

    // Canonical field tuple; fields a format does not carry are zeroed
    function automatic logic [63:0] mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [6:0] f7, input logic [31:0] imm);
        bit has_rd  = f inside {FMT_R, FMT_I, FMT_SHIFT, FMT_U, FMT_J};
        bit has_rs1 = !(f inside {FMT_U, FMT_J});
        bit has_rs2 = f inside {FMT_R, FMT_S, FMT_B};
        bit has_f7  = f inside {FMT_R, FMT_SHIFT};
        return {op, has_rd ? rd : 5'd0, has_rs1 ? f3 : 3'd0, has_rs1 ? rs1 : 5'd0,
                has_rs2 ? rs2 : 5'd0, has_f7 ? f7 : 7'd0, imm};
    endfunction

    function automatic logic [63:0] decode(input logic [2:0] f, input logic [31:0] w);
        logic [31:0] imm;
        imm = f == FMT_I ? {{20{w[31]}}, w[31:20]} :
              f == FMT_S ? {{20{w[31]}}, w[31:25], w[11:7]} :
              f == FMT_B ? {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} :
              f == FMT_U ? {w[31:12], 12'd0} :
              f == FMT_J ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} :
              f == FMT_SHIFT ? {27'd0, w[24:20]} : 32'd0;
        return mk(f, w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25], imm);
    endfunction

    function automatic int sx(input int v, input int b);
        int m = 1 << b;
        int t = v & (m - 1);
        return (t >= m / 2) ? t - m : t;
    endfunction

    task automatic push(input logic [2:0] f, input logic [63:0] t, input bit er, input bit last);
        exp_t e;
        e.f = f;
        e.v = {t, er, last};
        exp_q.push_back(e);
    endtask

    task automatic model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int imm);
        int ei;
        bit er;
        logic [31:0] u;
        u = imm;
        if (f == FMT_LI) begin
            if (imm >= -2048 && imm <= 2047)
                push(FMT_I, mk(FMT_I, 7'h13, rd, 3'd0, 5'd0, 5'd0, 7'd0, imm), 0, 1);
            else if ((imm & 'hFFF) == 0)
                push(FMT_U, mk(FMT_U, 7'h37, rd, 3'd0, 5'd0, 5'd0, 7'd0, imm), 0, 1);
            else begin
                push(FMT_U, mk(FMT_U, 7'h37, rd, 3'd0, 5'd0, 5'd0, 7'd0, (u + 32'h800) & 32'hFFFFF000), 0, 0);
                push(FMT_I, mk(FMT_I, 7'h13, rd, 3'd0, rd, 5'd0, 7'd0, sx(imm, 12)), 0, 1);
            end
        end else begin
            case (f)
                FMT_I, FMT_S: begin ei = sx(imm, 12); er = imm < -2048 || imm > 2047; end
                FMT_B: begin ei = sx(imm, 13) & ~1; er = imm < -4096 || imm > 4094 || imm[0]; end
                FMT_J: begin ei = sx(imm, 21) & ~1; er = imm < -1048576 || imm > 1048574 || imm[0]; end
                FMT_U: begin ei = imm & 32'hFFFFF000; er = (imm & 'hFFF) != 0; end
                FMT_SHIFT: begin ei = imm & 31; er = (imm & ~31) != 0; end
                default: begin ei = 0; er = 0; end
            endcase
            push(f, mk(f, op, rd, f3, rs1, rs2, f7, ei), er, 1);
        end
    endtask

    function automatic int rimm();
        int b[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                      1048576, -1048576, 1048574, 32};
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return int'($urandom_range(0, 4095)) - 2048;
            2: return b[$urandom_range(0, 11)];
            3: return $urandom & 32'hFFFFF000;
            4: return $urandom_range(0, 40);
            default: return int'($urandom_range(0, 9999)) - 5000;
        endcase
    endfunction

    int sent, cyc;
    bit acc;
    exp_t e;

    initial begin
        rst = 1; in_valid = 0; out_ready = 1;
        drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        in_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_instr", out_instr, 0);
        chk("rst_err", out_err, 0);
        chk("rst_last", out_last, 0);
        rst = 0;
        drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -1);
        step(); in_valid = 0;
        chk("i_valid", out_valid, 1);
        chk("i_word", out_instr, 32'hFFF00093);
        chk("i_err", out_err, 0);
        chk("i_last", out_last, 1);
        drive(FMT_LI, 7'h7F, 3'd5, 7'd0, 5'd5, 5'd9, 5'd9, 32'h12345FFF);
        step(); in_valid = 0;
        chk("li_hi_word", out_instr, 32'h123462B7);
        chk("li_hi_last", out_last, 0);
        chk("li_hi_ready", in_ready, 0);
        step();
        chk("li_lo_word", out_instr, 32'hFFF28293);
        chk("li_lo_last", out_last, 1);
        step();
        chk("li_done", out_valid, 0);
        drive(FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -8);
        step();
        chk("b_word", out_instr, 32'hFE208CE3);
        chk("b_err", out_err, 0);
        drive(FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 3);
        step();
        chk("b_odd_err", out_err, 1);
        drive(FMT_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 2048);
        step();
        chk("j_word", out_instr, 32'h001000EF);
        chk("j_err", out_err, 0);
        drive(FMT_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h100000);
        step(); in_valid = 0;
        chk("j_range_err", out_err, 1);
        step();
        out_ready = 0;
        drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 5);
        step();
        drive(FMT_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_word", out_instr, 32'h00518113);
            chk("bp_ready", in_ready, 0);
            step();
        end
        out_ready = 1; #1;
        chk("bp_release_ready", in_ready, 1);
        step(); in_valid = 0;
        chk("bp_next_word", out_instr, 32'h002081B3);
        step();
        chk("bp_empty", out_valid, 0);
        out_ready = 0;
        drive(FMT_LI, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        step(); in_valid = 0;
        chk("rli_hi_last", out_last, 0);
        rst = 1;
        step(); rst = 0;
        chk("rli_valid", out_valid, 0);
        chk("rli_ready", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rli_no_addi", out_valid, 0);
        end
        sent = 0; cyc = 0; acc = 0;
        while ((sent < 400 || exp_q.size() != 0) && cyc < 5000) begin
            if (acc) in_valid = 0;
            acc = 0;
            out_ready = $urandom_range(0, 3) != 0;
            if (!in_valid && sent < 400 && $urandom_range(0, 4) != 0)
                drive($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, rimm());
            #1;
            if (out_valid && out_ready) begin
                chk("rand_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rand_word", {decode(e.f, out_instr), out_err, out_last}, e.v);
                end
            end
            if (in_valid && in_ready) begin
                model(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                sent++;
                acc = 1;
            end
            step();
            cyc++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_sent", sent, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
